// File: rtl/apu_aout_if.sv
// FIFO-side and output-stage-side signals of the APU audio output sequencer.
// master = sequencer, slave = FIFO/PWM environment.
interface apu_aout_if #(
  parameter int LEVEL_W = 5
);
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_rvalid;
  logic [31:0]        fifo_rdata;
  logic               fifo_pop;
  logic               aout_en;
  logic [31:0]        aout_sample;
  logic               aout_sample_rdy;

  modport master (
    input  fifo_level, fifo_rvalid, fifo_rdata, aout_sample_rdy,
    output fifo_pop, aout_en, aout_sample
  );

  modport slave (
    output fifo_level, fifo_rvalid, fifo_rdata, aout_sample_rdy,
    input  fifo_pop, aout_en, aout_sample
  );
endinterface

// File: rtl/apu_aout_ctrl.sv
// Sequencer between the APU sample FIFO and the PWM output stage: prime, soft
// shift-ramp on start/stop, one sample per consume pulse, underflow counting.
//  state       | meaning
//  S_IDLE      | output off, sample held 0, atten 15
//  S_PRIME     | waiting for FIFO level to reach prime_level
//  S_RAMP_UP   | output on, atten stepping down toward 0
//  S_RUN       | output on, full scale
//  S_RAMP_DOWN | output on, atten stepping up, leaves to IDLE after step at 15
module apu_aout_ctrl #(
  parameter int LEVEL_W    = 5,
  parameter int UFLOW_W    = 8,
  parameter int RAMP_DIV_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_enable,
  input  logic [LEVEL_W-1:0] prime_level,
  input  logic               uflow_clr,
  output logic               running,
  output logic [UFLOW_W-1:0] uflow_count,
  apu_aout_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RAMP_UP, S_RUN, S_RAMP_DOWN
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            atten_q, atten_d;
  logic [RAMP_DIV_W-1:0] step_q, step_d;
  logic [31:0]           last_q, last_d;
  logic [31:0]           sample_q, sample_d;
  logic [UFLOW_W-1:0]    uflow_q, uflow_d;

  logic              aout_en, consume, pop, uflow_evt, wrap;
  logic [31:0]       src;
  logic signed [15:0] src_l, src_r, shl, shr;
  logic [3:0]        atten_dec;

  always_comb begin
    state_d   = state_q;
    atten_d   = atten_q;
    step_d    = step_q;
    last_d    = last_q;
    sample_d  = sample_q;
    uflow_d   = uflow_q;

    aout_en   = (state_q == S_RAMP_UP) || (state_q == S_RUN) || (state_q == S_RAMP_DOWN);
    consume   = aout_en && bus.aout_sample_rdy;
    pop       = consume && bus.fifo_rvalid;
    src       = pop ? bus.fifo_rdata : last_q;
    uflow_evt = consume && !bus.fifo_rvalid &&
                ((state_q == S_RAMP_UP) || (state_q == S_RUN));
    wrap      = consume && (step_q == {RAMP_DIV_W{1'b1}});
    src_l     = src[31:16];
    src_r     = src[15:0];
    shl       = src_l >>> atten_q;
    shr       = src_r >>> atten_q;
    atten_dec = (atten_q == 4'd0) ? 4'd0 : atten_q - 4'd1;

    if (pop)
      last_d = bus.fifo_rdata;
    if (consume)
      sample_d = {shl, shr};
    if (consume && ((state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN)))
      step_d = step_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        sample_d = '0;
        atten_d  = 4'd15;
        step_d   = '0;
        if (ctrl_enable)
          state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!ctrl_enable)
          state_d = S_IDLE;
        else if (bus.fifo_level >= prime_level)
          state_d = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (!ctrl_enable) begin
          state_d = S_RAMP_DOWN;
          step_d  = '0;
        end else if (wrap) begin
          atten_d = atten_dec;
          if (atten_dec == 4'd0)
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        atten_d = 4'd0;
        if (!ctrl_enable) begin
          state_d = S_RAMP_DOWN;
          step_d  = '0;
        end
      end
      S_RAMP_DOWN: begin
        if (ctrl_enable) begin
          state_d = S_RAMP_UP;
          step_d  = '0;
        end else if (wrap) begin
          if (atten_q == 4'd15) begin
            // fully attenuated: drop the output and leave a clean zero behind
            state_d  = S_IDLE;
            sample_d = '0;
          end else begin
            atten_d = atten_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (uflow_clr)
      uflow_d = uflow_evt ? {{(UFLOW_W-1){1'b0}}, 1'b1} : '0;
    else if (uflow_evt && (uflow_q != {UFLOW_W{1'b1}}))
      uflow_d = uflow_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      atten_q  <= 4'd15;
      step_q   <= '0;
      last_q   <= '0;
      sample_q <= '0;
      uflow_q  <= '0;
    end else begin
      state_q  <= state_d;
      atten_q  <= atten_d;
      step_q   <= step_d;
      last_q   <= last_d;
      sample_q <= sample_d;
      uflow_q  <= uflow_d;
    end
  end

  assign bus.fifo_pop    = pop;
  assign bus.aout_en     = aout_en;
  assign bus.aout_sample = sample_q;
  assign running         = (state_q == S_RUN);
  assign uflow_count     = uflow_q;

endmodule

// File: tb/tb_apu_aout_ctrl.sv
// Directed bench for apu_aout_ctrl with a behavioural show-ahead FIFO model.
module tb_apu_aout_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_enable;
  logic [4:0] prime_level;
  logic       uflow_clr;
  logic       running;
  logic [7:0] uflow_count;

  int errors = 0;
  int checks = 0;

  apu_aout_if #(.LEVEL_W(5)) bus ();

  apu_aout_ctrl #(.LEVEL_W(5), .UFLOW_W(8), .RAMP_DIV_W(4)) dut (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .prime_level(prime_level),
    .uflow_clr(uflow_clr), .running(running), .uflow_count(uflow_count), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int occ;

  assign occ             = wr_ptr - rd_ptr;
  assign bus.fifo_rvalid = (occ != 0);
  assign bus.fifo_rdata  = mem[rd_ptr[9:0]];
  assign bus.fifo_level  = (occ > 31) ? 5'd31 : 5'(occ);

  always @(posedge clk) if (bus.fifo_pop && occ != 0) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[9:0]] = v;
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // one output-stage consume pulse; returns with aout_sample showing the load
  task automatic pulse_rdy(output logic pop_seen);
    bus.aout_sample_rdy = 1'b1;
    #1 pop_seen = bus.fifo_pop;
    @(posedge clk);
    @(negedge clk);
    bus.aout_sample_rdy = 1'b0;
  endtask

  function automatic logic [31:0] att(input logic [31:0] s, input int a);
    logic signed [15:0] l, r;
    l = s[31:16];
    r = s[15:0];
    return {16'(l >>> a), 16'(r >>> a)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; ctrl_enable = 1'b0; prime_level = 5'd0; uflow_clr = 1'b0;
    bus.aout_sample_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.aout_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", bus.aout_en); end
    checks++; if (bus.aout_sample !== 32'h0) begin errors++; $display("FAIL reset_sample got=%h exp=0", bus.aout_sample); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (uflow_count !== 8'd0) begin errors++; $display("FAIL reset_uflow got=%0d exp=0", uflow_count); end
    checks++; if (bus.fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", bus.fifo_pop); end
    @(negedge clk);
    bus.aout_sample_rdy = 1'b0;
  endtask

  task automatic test_prime();
    prime_level = 5'd8;
    push(32'h7FFF_8000, 7);
    ctrl_enable = 1'b1;
    bus.aout_sample_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk); #1;
      checks++; if (bus.aout_en !== 1'b0) begin errors++; $display("FAIL prime_en c%0d got=%b exp=0", i, bus.aout_en); end
      checks++; if (bus.fifo_pop !== 1'b0) begin errors++; $display("FAIL prime_pop c%0d got=%b exp=0", i, bus.fifo_pop); end
    end
    bus.aout_sample_rdy = 1'b0;
    push(32'h7FFF_8000, 1);
    #1;
    checks++; if (bus.aout_en !== 1'b0) begin errors++; $display("FAIL prime_edge got=%b exp=0", bus.aout_en); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.aout_en !== 1'b1) begin errors++; $display("FAIL prime_rise got=%b exp=1", bus.aout_en); end
    checks++; if (bus.aout_sample !== 32'h0) begin errors++; $display("FAIL prime_held0 got=%h exp=0", bus.aout_sample); end
    push(32'h7FFF_8000, 292);
    push(32'h1234_ABCD, 1);
  endtask

  task automatic test_ramp_up();
    logic p;
    for (int k = 0; k < 240; k++) begin
      pulse_rdy(p);
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL rampup_pop k%0d got=%b exp=1", k, p); end
      checks++; if (bus.aout_sample !== att(32'h7FFF_8000, 15 - k / 16))
        begin errors++; $display("FAIL rampup_smp k%0d got=%h exp=%h", k, bus.aout_sample, att(32'h7FFF_8000, 15 - k / 16)); end
      checks++; if (running !== (k == 239)) begin errors++; $display("FAIL rampup_run k%0d got=%b exp=%b", k, running, k == 239); end
    end
    checks++; if (att(32'h7FFF_8000, 15) !== 32'h0000_FFFF) begin errors++; $display("FAIL att15 got=%h exp=0000ffff", att(32'h7FFF_8000, 15)); end
  endtask

  task automatic test_underflow();
    logic p;
    logic [31:0] e;
    while (occ != 0) begin
      e = mem[rd_ptr[9:0]];
      pulse_rdy(p);
      checks++; if (bus.aout_sample !== e) begin errors++; $display("FAIL drain_smp got=%h exp=%h", bus.aout_sample, e); end
    end
    for (int i = 0; i < 3; i++) begin
      pulse_rdy(p);
      checks++; if (p !== 1'b0) begin errors++; $display("FAIL uf_pop i%0d got=%b exp=0", i, p); end
      checks++; if (bus.aout_sample !== 32'h1234_ABCD) begin errors++; $display("FAIL uf_repeat i%0d got=%h exp=1234abcd", i, bus.aout_sample); end
    end
    checks++; if (uflow_count !== 8'd3) begin errors++; $display("FAIL uf_count got=%0d exp=3", uflow_count); end
  endtask

  task automatic test_uflow_sat();
    logic p;
    for (int i = 0; i < 252; i++) pulse_rdy(p);
    checks++; if (uflow_count !== 8'd255) begin errors++; $display("FAIL uf_255 got=%0d exp=255", uflow_count); end
    pulse_rdy(p);
    checks++; if (uflow_count !== 8'd255) begin errors++; $display("FAIL uf_sat got=%0d exp=255", uflow_count); end
    uflow_clr = 1'b1;
    pulse_rdy(p);
    uflow_clr = 1'b0;
    checks++; if (uflow_count !== 8'd1) begin errors++; $display("FAIL uf_clr_evt got=%0d exp=1", uflow_count); end
    uflow_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    uflow_clr = 1'b0;
    checks++; if (uflow_count !== 8'd0) begin errors++; $display("FAIL uf_clr got=%0d exp=0", uflow_count); end
  endtask

  task automatic test_back_to_back();
    logic p;
    int pops;
    int rd0;
    push(32'h4000_C000, 448);
    rd0 = rd_ptr;
    pops = 0;
    ctrl_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 96; k++) begin
      pulse_rdy(p);
      if (p) pops++;
      checks++; if (bus.aout_sample !== att(32'h4000_C000, k / 16))
        begin errors++; $display("FAIL rampdn_smp k%0d got=%h exp=%h", k, bus.aout_sample, att(32'h4000_C000, k / 16)); end
    end
    ctrl_enable = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 96; k++) begin
      pulse_rdy(p);
      if (p) pops++;
      checks++; if (bus.aout_sample !== att(32'h4000_C000, 6 - k / 16))
        begin errors++; $display("FAIL reup_smp k%0d got=%h exp=%h", k, bus.aout_sample, att(32'h4000_C000, 6 - k / 16)); end
    end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reup_run got=%b exp=1", running); end
    checks++; if (pops !== 192) begin errors++; $display("FAIL reup_pops got=%0d exp=192", pops); end
    checks++; if (rd_ptr - rd0 !== 192) begin errors++; $display("FAIL reup_fifo got=%0d exp=192", rd_ptr - rd0); end
  endtask

  task automatic test_ramp_down_full();
    logic p;
    ctrl_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      pulse_rdy(p);
      if (k < 255) begin
        checks++; if (bus.aout_sample !== att(32'h4000_C000, k / 16))
          begin errors++; $display("FAIL dn_smp k%0d got=%h exp=%h", k, bus.aout_sample, att(32'h4000_C000, k / 16)); end
      end
      checks++; if (bus.aout_en !== (k < 255)) begin errors++; $display("FAIL dn_en k%0d got=%b exp=%b", k, bus.aout_en, k < 255); end
    end
    checks++; if (bus.aout_sample !== 32'h0) begin errors++; $display("FAIL dn_zero got=%h exp=0", bus.aout_sample); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL dn_run got=%b exp=0", running); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.aout_en !== 1'b0) begin errors++; $display("FAIL dn_idle got=%b exp=0", bus.aout_en); end
  endtask

  task automatic test_rst_mid_ramp();
    logic p;
    prime_level = 5'd0;
    ctrl_enable = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++; if (bus.aout_en !== 1'b1) begin errors++; $display("FAIL rr_en got=%b exp=1", bus.aout_en); end
    pulse_rdy(p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL rr_pop got=%b exp=0", p); end
    checks++; if (bus.aout_sample !== 32'h0000_FFFF) begin errors++; $display("FAIL rr_smp got=%h exp=0000ffff", bus.aout_sample); end
    checks++; if (uflow_count !== 8'd1) begin errors++; $display("FAIL rr_uf got=%0d exp=1", uflow_count); end
    rst = 1'b1;
    ctrl_enable = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.aout_en !== 1'b0) begin errors++; $display("FAIL rr_rst_en got=%b exp=0", bus.aout_en); end
    checks++; if (bus.aout_sample !== 32'h0) begin errors++; $display("FAIL rr_rst_smp got=%h exp=0", bus.aout_sample); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rr_rst_run got=%b exp=0", running); end
    checks++; if (uflow_count !== 8'd0) begin errors++; $display("FAIL rr_rst_uf got=%0d exp=0", uflow_count); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.aout_en !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b exp=0", bus.aout_en); end
  endtask

  initial begin
    bus.aout_sample_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_prime();
    test_ramp_up();
    test_underflow();
    test_uflow_sat();
    test_back_to_back();
    test_ramp_down_full();
    test_rst_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
